// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM: at most one memory transaction outstanding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_ME = 2'd2
    } state_t;

    // Outcome of the per-cycle priority decision.
    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_IF   = 2'd1,
        WIN_ME   = 2'd2
    } winner_t;

    // Access size encodings (funct3[1:0]).
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Default number of back-to-back data grants allowed while a fetch waits.
    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory port of the arbiter.
interface mem_arbiter_if;

    // Fetch port
    logic        IF_REQ;
    logic [15:0] IF_ADDR;
    logic        IF_GNT;
    logic        IF_RVALID;
    logic [31:0] IF_RDATA;

    // Data (load/store) port
    logic        ME_REQ;
    logic        ME_WE;
    logic [15:0] ME_ADDR;
    logic [31:0] ME_WDATA;
    logic [1:0]  ME_SIZE;
    logic        ME_GNT;
    logic        ME_RVALID;
    logic [31:0] ME_RDATA;

    // Shared single-port memory
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [1:0]  MEM_SIZE;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;

    // Arbiter view
    modport slave (
        input  IF_REQ, IF_ADDR,
        input  ME_REQ, ME_WE, ME_ADDR, ME_WDATA, ME_SIZE,
        input  MEM_ACK, MEM_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA,
        output ME_GNT, ME_RVALID, ME_RDATA,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE
    );

    // Requester / memory-model view
    modport master (
        output IF_REQ, IF_ADDR,
        output ME_REQ, ME_WE, ME_ADDR, ME_WDATA, ME_SIZE,
        output MEM_ACK, MEM_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA,
        input  ME_GNT, ME_RVALID, ME_RDATA,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE
    );

endinterface

// File: rtl/mem_arbiter_arb_select.sv
// Priority selection: data port wins unless a waiting fetch has been
// passed over STARVE_LIMIT times in a row.
module arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic       IF_REQ,
    input  logic       ME_REQ,
    input  logic [2:0] starve_cnt,
    output winner_t    winner
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    // Pick the winner for the current cycle.
    always_comb begin
        winner = WIN_NONE;
        if (ME_REQ && (!IF_REQ || (starve_cnt < LIMIT))) begin
            winner = WIN_ME;
        end else if (IF_REQ) begin
            winner = WIN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) in front of a shared
// single-port memory. One transaction in flight; grants are combinational in
// IDLE, the memory command and return data are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    mem_arbiter_if.slave  bus
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t     state;
    logic [2:0] starve_cnt;
    winner_t    winner;

    arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb_select (
        .IF_REQ     (bus.IF_REQ),
        .ME_REQ     (bus.ME_REQ),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );

    // Grants only in IDLE, and never while reset is held.
    assign bus.IF_GNT = RST_N && (state == IDLE) && (winner == WIN_IF);
    assign bus.ME_GNT = RST_N && (state == IDLE) && (winner == WIN_ME);

    // FSM, latched memory command, return data and starvation counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            bus.MEM_REQ   <= 1'b0;
            bus.MEM_WE    <= 1'b0;
            bus.MEM_ADDR  <= '0;
            bus.MEM_WDATA <= '0;
            bus.MEM_SIZE  <= '0;
            bus.IF_RVALID <= 1'b0;
            bus.ME_RVALID <= 1'b0;
            bus.IF_RDATA  <= '0;
            bus.ME_RDATA  <= '0;
        end else begin
            bus.IF_RVALID <= 1'b0;
            bus.ME_RVALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.IF_GNT) begin
                        state         <= BUSY_IF;
                        starve_cnt    <= '0;
                        bus.MEM_REQ   <= 1'b1;
                        bus.MEM_WE    <= 1'b0;
                        bus.MEM_ADDR  <= bus.IF_ADDR;
                        bus.MEM_WDATA <= '0;
                        bus.MEM_SIZE  <= SIZE_WORD;
                    end else if (bus.ME_GNT) begin
                        state         <= BUSY_ME;
                        bus.MEM_REQ   <= 1'b1;
                        bus.MEM_WE    <= bus.ME_WE;
                        bus.MEM_ADDR  <= bus.ME_ADDR;
                        bus.MEM_WDATA <= bus.ME_WDATA;
                        bus.MEM_SIZE  <= bus.ME_SIZE;
                        // Count only grants that made a fetch wait; saturate.
                        if (bus.IF_REQ && (starve_cnt < LIMIT)) begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
                    end
                end
                BUSY_IF: begin
                    if (bus.MEM_ACK) begin
                        state         <= IDLE;
                        bus.MEM_REQ   <= 1'b0;
                        bus.IF_RDATA  <= bus.MEM_RDATA;
                        bus.IF_RVALID <= 1'b1;
                    end
                end
                BUSY_ME: begin
                    if (bus.MEM_ACK) begin
                        state         <= IDLE;
                        bus.MEM_REQ   <= 1'b0;
                        // Stores return zero so a stale read bus never leaks out.
                        bus.ME_RDATA  <= bus.MEM_WE ? 32'h0 : bus.MEM_RDATA;
                        bus.ME_RVALID <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.MEM_REQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-requester transactions
// followed by hand-written multi-cycle sequences.
module tb_mem_arbiter;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_fetch;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          delay;
        logic [31:0] mem_rdata;
        logic        exp_we;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        bus.IF_REQ   = v.is_fetch;
        bus.ME_REQ   = !v.is_fetch;
        bus.IF_ADDR  = v.addr;
        bus.ME_ADDR  = v.addr;
        bus.ME_WE    = v.we;
        bus.ME_WDATA = v.wdata;
        bus.ME_SIZE  = v.size;
        #1;
        chk1("if_gnt", bus.IF_GNT, v.is_fetch);
        chk1("me_gnt", bus.ME_GNT, !v.is_fetch);
        chk1("mem_req_before_grant", bus.MEM_REQ, 1'b0);
        tick();
        bus.IF_REQ = 1'b0;
        bus.ME_REQ = 1'b0;
        for (int i = 0; i <= v.delay; i++) begin
            if (i == v.delay) begin
                bus.MEM_ACK   = 1'b1;
                bus.MEM_RDATA = v.mem_rdata;
            end
            #1;
            chk1("mem_req_busy", bus.MEM_REQ, 1'b1);
            chk1("mem_we", bus.MEM_WE, v.exp_we);
            chk32("mem_addr", {16'h0, bus.MEM_ADDR}, {16'h0, v.addr});
            chk32("mem_size", {30'h0, bus.MEM_SIZE}, {30'h0, v.exp_size});
            if (v.exp_we) chk32("mem_wdata", bus.MEM_WDATA, v.exp_wdata);
            chk1("no_rvalid_busy", bus.IF_RVALID | bus.ME_RVALID, 1'b0);
            chk1("no_gnt_busy", bus.IF_GNT | bus.ME_GNT, 1'b0);
            tick();
        end
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 32'h0BAD_0BAD;
        #1;
        chk1("mem_req_after_ack", bus.MEM_REQ, 1'b0);
        if (v.is_fetch) begin
            chk1("if_rvalid", bus.IF_RVALID, 1'b1);
            chk1("me_rvalid_idle", bus.ME_RVALID, 1'b0);
            chk32("if_rdata", bus.IF_RDATA, v.exp_rdata);
        end else begin
            chk1("me_rvalid", bus.ME_RVALID, 1'b1);
            chk1("if_rvalid_idle", bus.IF_RVALID, 1'b0);
            chk32("me_rdata", bus.ME_RDATA, v.exp_rdata);
        end
        tick();
        #1;
        chk1("rvalid_one_cycle", bus.IF_RVALID | bus.ME_RVALID, 1'b0);
        if (v.is_fetch) chk32("if_rdata_hold", bus.IF_RDATA, v.exp_rdata);
        else            chk32("me_rdata_hold", bus.ME_RDATA, v.exp_rdata);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // is_fetch, we, addr, wdata, size, delay, mem_rdata, exp_we, exp_size, exp_wdata, exp_rdata
        vecs[0] = '{1'b1, 1'b1, 16'h0010, 32'h1111_2222, 2'b00, 2, 32'hDEAD_BEEF, 1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b0, 16'h0200, 32'h0,         2'b00, 0, 32'h0000_00A5, 1'b0, 2'b00, 32'h0, 32'h0000_00A5};
        vecs[2] = '{1'b0, 1'b1, 16'h0204, 32'hCAFE_F00D, 2'b01, 1, 32'hFFFF_FFFF, 1'b1, 2'b01, 32'hCAFE_F00D, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFC, 32'h0,         2'b01, 0, 32'h1357_9BDF, 1'b0, 2'b10, 32'h0, 32'h1357_9BDF};
        vecs[4] = '{1'b0, 1'b0, 16'h0300, 32'h0,         2'b10, 3, 32'h89AB_CDEF, 1'b0, 2'b10, 32'h0, 32'h89AB_CDEF};

        // Reset held with both requests up: no grants, all outputs cleared.
        RST_N         = 1'b0;
        bus.IF_REQ    = 1'b1;
        bus.ME_REQ    = 1'b1;
        bus.IF_ADDR   = 16'h0;
        bus.ME_WE     = 1'b0;
        bus.ME_ADDR   = 16'h0;
        bus.ME_WDATA  = 32'h0;
        bus.ME_SIZE   = 2'b00;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk1("rst_if_gnt", bus.IF_GNT, 1'b0);
        chk1("rst_me_gnt", bus.ME_GNT, 1'b0);
        chk1("rst_mem_req", bus.MEM_REQ, 1'b0);
        chk32("rst_mem_addr", {16'h0, bus.MEM_ADDR}, 32'h0);
        chk32("rst_if_rdata", bus.IF_RDATA, 32'h0);
        chk32("rst_me_rdata", bus.ME_RDATA, 32'h0);
        chk1("rst_rvalid", bus.IF_RVALID | bus.ME_RVALID, 1'b0);
        bus.IF_REQ = 1'b0;
        bus.ME_REQ = 1'b0;
        RST_N      = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Simultaneous requests: store wins first, fetch granted the cycle after ACK.
        bus.IF_REQ   = 1'b1;
        bus.IF_ADDR  = 16'h0040;
        bus.ME_REQ   = 1'b1;
        bus.ME_WE    = 1'b1;
        bus.ME_ADDR  = 16'h0100;
        bus.ME_WDATA = 32'h1234_5678;
        bus.ME_SIZE  = 2'b10;
        #1;
        chk1("both_me_gnt", bus.ME_GNT, 1'b1);
        chk1("both_if_gnt", bus.IF_GNT, 1'b0);
        tick();
        bus.ME_REQ    = 1'b0;
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'h5555_5555;
        #1;
        chk1("both_mem_we", bus.MEM_WE, 1'b1);
        chk32("both_mem_addr", {16'h0, bus.MEM_ADDR}, 32'h0000_0100);
        chk32("both_mem_wdata", bus.MEM_WDATA, 32'h1234_5678);
        chk1("no_gnt_in_ack_cycle", bus.IF_GNT, 1'b0);
        tick();
        bus.MEM_ACK = 1'b0;
        #1;
        chk1("store_rvalid", bus.ME_RVALID, 1'b1);
        chk32("store_rdata_zero", bus.ME_RDATA, 32'h0);
        chk1("if_gnt_after_ack", bus.IF_GNT, 1'b1);
        tick();
        bus.IF_REQ    = 1'b0;
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'h0000_1111;
        #1;
        chk1("fetch_mem_req", bus.MEM_REQ, 1'b1);
        chk32("fetch_mem_addr", {16'h0, bus.MEM_ADDR}, 32'h0000_0040);
        chk1("fetch_mem_we", bus.MEM_WE, 1'b0);
        tick();
        bus.MEM_ACK = 1'b0;
        #1;
        chk1("fetch_rvalid", bus.IF_RVALID, 1'b1);
        chk32("fetch_rdata", bus.IF_RDATA, 32'h0000_1111);
        tick();

        // Both held, zero-latency ACK: ME,ME,ME,ME,IF repeating.
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 16'h0500;
        bus.ME_REQ  = 1'b1;
        bus.ME_WE   = 1'b0;
        bus.ME_ADDR = 16'h0300;
        for (int g = 0; g < 10; g++) begin
            #1;
            chk1($sformatf("starve_if_gnt_%0d", g), bus.IF_GNT, (g % 5) == 4);
            chk1($sformatf("starve_me_gnt_%0d", g), bus.ME_GNT, (g % 5) != 4);
            tick();
            bus.MEM_ACK   = 1'b1;
            bus.MEM_RDATA = 32'h100 + 32'(g);
            tick();
            bus.MEM_ACK = 1'b0;
        end
        bus.IF_REQ = 1'b0;
        bus.ME_REQ = 1'b0;
        tick();

        // Reset in the middle of a store: command drops at once, late ACK ignored.
        bus.ME_REQ   = 1'b1;
        bus.ME_WE    = 1'b1;
        bus.ME_ADDR  = 16'h0700;
        bus.ME_WDATA = 32'hA5A5_A5A5;
        bus.ME_SIZE  = 2'b10;
        #1;
        chk1("rst_seq_me_gnt", bus.ME_GNT, 1'b1);
        tick();
        bus.ME_REQ = 1'b0;
        #1;
        chk1("rst_seq_busy", bus.MEM_REQ, 1'b1);
        RST_N = 1'b0;
        #1;
        chk1("async_rst_mem_req", bus.MEM_REQ, 1'b0);
        chk1("async_rst_mem_we", bus.MEM_WE, 1'b0);
        chk32("async_rst_mem_addr", {16'h0, bus.MEM_ADDR}, 32'h0);
        chk32("async_rst_mem_wdata", bus.MEM_WDATA, 32'h0);
        chk32("async_rst_if_rdata", bus.IF_RDATA, 32'h0);
        tick();
        chk1("rst_seq_no_rvalid", bus.IF_RVALID | bus.ME_RVALID, 1'b0);
        RST_N         = 1'b1;
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'hFFFF_0000;
        tick();
        bus.MEM_ACK = 1'b0;
        #1;
        chk1("late_ack_no_rvalid", bus.IF_RVALID | bus.ME_RVALID, 1'b0);
        chk1("late_ack_no_mem_req", bus.MEM_REQ, 1'b0);
        chk32("late_ack_me_rdata", bus.ME_RDATA, 32'h0);
        tick();

        // Stray ACK in IDLE with no requests.
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'h7777_7777;
        tick();
        bus.MEM_ACK = 1'b0;
        #1;
        chk1("idle_ack_no_rvalid", bus.IF_RVALID | bus.ME_RVALID, 1'b0);
        chk1("idle_ack_no_mem_req", bus.MEM_REQ, 1'b0);
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = 16'h0020;
        #1;
        chk1("idle_ack_still_idle", bus.IF_GNT, 1'b1);

        // Data request withdrawn while a fetch is in flight.
        tick();
        bus.IF_REQ  = 1'b0;
        bus.ME_REQ  = 1'b1;
        bus.ME_WE   = 1'b0;
        bus.ME_ADDR = 16'h0800;
        #1;
        chk1("withdraw_busy", bus.MEM_REQ, 1'b1);
        chk1("withdraw_no_gnt_a", bus.ME_GNT, 1'b0);
        tick();
        bus.ME_REQ    = 1'b0;
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'h2468_ACE0;
        #1;
        chk1("withdraw_no_gnt_b", bus.ME_GNT, 1'b0);
        tick();
        bus.MEM_ACK = 1'b0;
        #1;
        chk1("withdraw_if_rvalid", bus.IF_RVALID, 1'b1);
        chk32("withdraw_if_rdata", bus.IF_RDATA, 32'h2468_ACE0);
        chk1("withdraw_no_me_rvalid", bus.ME_RVALID, 1'b0);
        chk1("withdraw_no_gnt_c", bus.ME_GNT, 1'b0);
        tick();
        #1;
        chk1("withdraw_no_me_rvalid_late", bus.ME_RVALID, 1'b0);
        chk1("withdraw_mem_idle", bus.MEM_REQ, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
